ps2_note_encoder: RTL and testbench



---
 rtl/ps2_note_encoder_if.sv | 31 +++
 rtl/ps2_note_encoder.sv | 249 ++++++++++++++++++++++++
 tb/tb_ps2_note_encoder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_note_encoder_if.sv
// PS/2 keyboard lines in, note events out.
// The master modport is the encoder side; the slave modport is the keyboard/controller side.
interface ps2_note_encoder_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       note_in;
  logic [3:0] note;
  logic [2:0] octave;
  logic       key_held;
  logic       frame_err;

  modport master (
    input  ps2_clk,
    input  ps2_dat,
    output note_in,
    output note,
    output octave,
    output key_held,
    output frame_err
  );

  modport slave (
    output ps2_clk,
    output ps2_dat,
    input  note_in,
    input  note,
    input  octave,
    input  key_held,
    input  frame_err
  );
endinterface

// File: rtl/ps2_note_encoder.sv
// PS/2 set-2 keyboard front-end.
// Receives 11-bit frames, decodes make/break codes and turns piano-layout keys into
// one-cycle note_in strobes. Z/X step the octave, which is captured with the next note.
module ps2_note_encoder #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int OCT_DEFAULT    = 4,
  parameter int OCT_MAX        = 6
) (
  input  logic                clk,
  input  logic                reset,
  ps2_note_encoder_if.master  bus
);

  localparam int             TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]  TO_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0]  TO_ONE  = TW'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_BREAK     = 2'd1,
    S_EXT       = 2'd2,
    S_EXT_BREAK = 2'd3
  } dec_state_t;

  // Odd parity holds when data bits plus parity bit have an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] v);
    return ^v;
  endfunction

  // Piano-layout scancode lookup: {hit, note index}.
  function automatic logic [4:0] key_to_note(input logic [7:0] code);
    case (code)
      8'h1C:   return {1'b1, 4'd0};
      8'h1D:   return {1'b1, 4'd1};
      8'h1B:   return {1'b1, 4'd2};
      8'h24:   return {1'b1, 4'd3};
      8'h23:   return {1'b1, 4'd4};
      8'h2B:   return {1'b1, 4'd5};
      8'h2C:   return {1'b1, 4'd6};
      8'h34:   return {1'b1, 4'd7};
      8'h35:   return {1'b1, 4'd8};
      8'h33:   return {1'b1, 4'd9};
      8'h3C:   return {1'b1, 4'd10};
      8'h3B:   return {1'b1, 4'd11};
      default: return {1'b0, 4'd0};
    endcase
  endfunction

  // Synchroniser and edge history
  logic r_clk_s1, r_clk_s2, r_clk_s3;
  logic r_dat_s1, r_dat_s2;
  logic w_fall;
  logic w_dat;

  // Receiver
  logic          r_busy;
  logic [3:0]    r_bit_cnt;
  logic [8:0]    r_shift;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]    r_byte;
  logic          r_byte_valid;
  logic          r_frame_err;

  // Decoder
  dec_state_t r_state, w_state;
  logic [3:0] r_note, w_note;
  logic       r_note_in, w_note_in;
  logic       r_key_held, w_key_held;
  logic [7:0] r_held_code, w_held_code;
  logic [2:0] r_oct_cur, w_oct_cur;
  logic [2:0] r_octave, w_octave;
  logic [4:0] w_key;

  // Two-flop synchronisers on both PS/2 lines plus one extra clock stage for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_s3 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= bus.ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_dat_s1 <= bus.ps2_dat;
      r_dat_s2 <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_s3 & ~r_clk_s2;
  assign w_dat  = r_dat_s2;

  // Frame receiver: shifts data/parity on falling edges, checks framing, watches for stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy       <= 1'b0;
      r_bit_cnt    <= 4'd0;
      r_shift      <= 9'd0;
      r_to_cnt     <= TO_ZERO;
      r_byte       <= 8'd0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_fall) begin
        r_to_cnt <= TO_ZERO;
        if (!r_busy) begin
          // Any edge seen while idle must be a start bit.
          if (w_dat == 1'b0) begin
            r_busy    <= 1'b1;
            r_bit_cnt <= 4'd1;
          end else begin
            r_frame_err <= 1'b1;
          end
        end else if (r_bit_cnt == 4'd10) begin
          r_busy    <= 1'b0;
          r_bit_cnt <= 4'd0;
          if (w_dat && odd_parity_ok(r_shift)) begin
            r_byte       <= r_shift[7:0];
            r_byte_valid <= 1'b1;
          end else begin
            r_frame_err <= 1'b1;
          end
        end else begin
          // Bits 1..9: eight data bits LSB first, then parity, all land in r_shift.
          r_shift   <= {w_dat, r_shift[8:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else if (r_busy) begin
        if (r_to_cnt == TO_LAST) begin
          r_busy      <= 1'b0;
          r_bit_cnt   <= 4'd0;
          r_to_cnt    <= TO_ZERO;
          r_frame_err <= 1'b1;
        end else begin
          r_to_cnt <= r_to_cnt + TO_ONE;
        end
      end else begin
        r_to_cnt <= TO_ZERO;
      end
    end
  end

  // Decoder state and registered note outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_note      <= 4'd0;
      r_note_in   <= 1'b0;
      r_key_held  <= 1'b0;
      r_held_code <= 8'd0;
      r_oct_cur   <= 3'(OCT_DEFAULT);
      r_octave    <= 3'(OCT_DEFAULT);
    end else begin
      r_state     <= w_state;
      r_note      <= w_note;
      r_note_in   <= w_note_in;
      r_key_held  <= w_key_held;
      r_held_code <= w_held_code;
      r_oct_cur   <= w_oct_cur;
      r_octave    <= w_octave;
    end
  end

  assign w_key = key_to_note(r_byte);

  // Make/break/extended decode; note and octave outputs change only together with note_in.
  always_comb begin
    w_state     = r_state;
    w_note      = r_note;
    w_note_in   = 1'b0;
    w_key_held  = r_key_held;
    w_held_code = r_held_code;
    w_oct_cur   = r_oct_cur;
    w_octave    = r_octave;
    if (r_byte_valid) begin
      case (r_state)
        S_IDLE: begin
          if (r_byte == 8'hF0) begin
            w_state = S_BREAK;
          end else if (r_byte == 8'hE0) begin
            w_state = S_EXT;
          end else begin
            w_state = S_IDLE;
            if (w_key[4]) begin
              // Typematic repeats of the held key are swallowed.
              if (r_key_held && (r_byte == r_held_code)) begin
                w_note_in = 1'b0;
              end else begin
                w_note      = w_key[3:0];
                w_note_in   = 1'b1;
                w_key_held  = 1'b1;
                w_held_code = r_byte;
                w_octave    = r_oct_cur;
              end
            end else if (r_byte == 8'h1A) begin
              if (r_oct_cur != 3'd0) begin
                w_oct_cur = r_oct_cur - 3'd1;
              end else begin
                w_oct_cur = r_oct_cur;
              end
            end else if (r_byte == 8'h22) begin
              if (r_oct_cur < 3'(OCT_MAX)) begin
                w_oct_cur = r_oct_cur + 3'd1;
              end else begin
                w_oct_cur = r_oct_cur;
              end
            end else begin
              w_oct_cur = r_oct_cur;
            end
          end
        end
        S_BREAK: begin
          w_state = S_IDLE;
          if (r_key_held && (r_byte == r_held_code)) begin
            w_key_held = 1'b0;
          end else begin
            w_key_held = r_key_held;
          end
        end
        S_EXT: begin
          if (r_byte == 8'hF0) begin
            w_state = S_EXT_BREAK;
          end else begin
            w_state = S_IDLE;
          end
        end
        S_EXT_BREAK: begin
          w_state = S_IDLE;
        end
        default: begin
          w_state = S_IDLE;
        end
      endcase
    end else begin
      w_state = r_state;
    end
  end

  assign bus.note_in   = r_note_in;
  assign bus.note      = r_note;
  assign bus.octave    = r_octave;
  assign bus.key_held  = r_key_held;
  assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_note_encoder.sv
// Directed, table-driven bench for ps2_note_encoder: PS/2 frames are bit-banged,
// output pulses are counted on the falling clock edge and compared to hand-computed values.
module tb_ps2_note_encoder;

  localparam int TO_CYC = 300;
  localparam int HALF   = 10;
  localparam int NVEC   = 28;

  logic clk;
  logic reset;

  ps2_note_encoder_if bus();

  ps2_note_encoder #(
    .TIMEOUT_CYCLES(TO_CYC),
    .OCT_DEFAULT   (4),
    .OCT_MAX       (6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    bit         bad;
    int         d_ni;
    int         note;
    int         oct;
    int         held;
    int         d_err;
  } vec_t;

  vec_t vt[NVEC];

  int n_chk = 0;
  int n_err = 0;

  int cyc      = 0;
  int n_ni     = 0;
  int n_fe     = 0;
  int n_double = 0;
  int ni_cyc   = 0;
  int fall_cyc = 0;
  logic prev_ni = 1'b0;

  // Cycle counter for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    prev_ni <= bus.note_in;
    if (bus.note_in) begin
      n_ni   <= n_ni + 1;
      ni_cyc <= cyc;
      if (prev_ni) n_double <= n_double + 1;
    end
    if (bus.frame_err) n_fe <= n_fe + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    bus.ps2_dat = b;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b0;
    fall_cyc = cyc;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad, input int nbits);
    logic [10:0] fr;
    logic        par;
    par = (~^code) ^ bad;
    fr  = {1'b1, par, code, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
    repeat (20) @(negedge clk);
  endtask

  task automatic set_vec(input int i, input logic [7:0] code, input bit bad, input int d_ni,
                         input int note, input int oct, input int held, input int d_err);
    vt[i] = '{code, bad, d_ni, note, oct, held, d_err};
  endtask

  initial begin
    int ni0, fe0;

    set_vec( 0, 8'h1C, 1'b0, 1, 0, 4, 1, 0);
    set_vec( 1, 8'h1C, 1'b0, 0, 0, 4, 1, 0);
    set_vec( 2, 8'h1C, 1'b0, 0, 0, 4, 1, 0);
    set_vec( 3, 8'hF0, 1'b0, 0, 0, 4, 1, 0);
    set_vec( 4, 8'h1C, 1'b0, 0, 0, 4, 0, 0);
    set_vec( 5, 8'h22, 1'b0, 0, 0, 4, 0, 0);
    set_vec( 6, 8'h22, 1'b0, 0, 0, 4, 0, 0);
    set_vec( 7, 8'h22, 1'b0, 0, 0, 4, 0, 0);
    set_vec( 8, 8'h35, 1'b0, 1, 8, 6, 1, 0);
    for (int i = 9; i < 17; i++) set_vec(i, 8'h1A, 1'b0, 0, 8, 6, 1, 0);
    set_vec(17, 8'h2C, 1'b0, 1, 6, 0, 1, 0);
    set_vec(18, 8'h1D, 1'b1, 0, 6, 0, 1, 1);
    set_vec(19, 8'h1D, 1'b0, 1, 1, 0, 1, 0);
    set_vec(20, 8'hE0, 1'b0, 0, 1, 0, 1, 0);
    set_vec(21, 8'h1C, 1'b0, 0, 1, 0, 1, 0);
    set_vec(22, 8'hE0, 1'b0, 0, 1, 0, 1, 0);
    set_vec(23, 8'hF0, 1'b0, 0, 1, 0, 1, 0);
    set_vec(24, 8'h1C, 1'b0, 0, 1, 0, 1, 0);
    set_vec(25, 8'hE0, 1'b0, 0, 1, 0, 1, 0);
    set_vec(26, 8'hF0, 1'b0, 0, 1, 0, 1, 0);
    set_vec(27, 8'h1D, 1'b0, 0, 1, 0, 1, 0);

    reset       = 1'b0;
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_note_in",   int'(bus.note_in),   0);
    chk("rst_note",      int'(bus.note),      0);
    chk("rst_octave",    int'(bus.octave),    4);
    chk("rst_key_held",  int'(bus.key_held),  0);
    chk("rst_frame_err", int'(bus.frame_err), 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      ni0 = n_ni;
      fe0 = n_fe;
      send_frame(vt[i].code, vt[i].bad, 11);
      chk($sformatf("v%0d_note_in_cnt", i), n_ni - ni0, vt[i].d_ni);
      chk($sformatf("v%0d_note", i),        int'(bus.note),     vt[i].note);
      chk($sformatf("v%0d_octave", i),      int'(bus.octave),   vt[i].oct);
      chk($sformatf("v%0d_key_held", i),    int'(bus.key_held), vt[i].held);
      chk($sformatf("v%0d_frame_err_cnt", i), n_fe - fe0,       vt[i].d_err);
      if (i == 0) chk("latency_stop_to_note_in", ni_cyc - fall_cyc, 4);
    end

    // Stalled frame: five bits then silence past the timeout.
    ni0 = n_ni;
    fe0 = n_fe;
    send_frame(8'h3B, 1'b0, 5);
    repeat (TO_CYC + 50) @(negedge clk);
    chk("timeout_frame_err_cnt", n_fe - fe0, 1);
    chk("timeout_note_in_cnt",   n_ni - ni0, 0);
    ni0 = n_ni;
    fe0 = n_fe;
    send_frame(8'h3B, 1'b0, 11);
    chk("after_timeout_note_in_cnt", n_ni - ni0, 1);
    chk("after_timeout_note",        int'(bus.note), 11);
    chk("after_timeout_octave",      int'(bus.octave), 0);
    chk("after_timeout_err_cnt",     n_fe - fe0, 0);

    // Reset in the middle of a frame.
    send_frame(8'h24, 1'b0, 4);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_note_in",   int'(bus.note_in),   0);
    chk("midrst_note",      int'(bus.note),      0);
    chk("midrst_octave",    int'(bus.octave),    4);
    chk("midrst_key_held",  int'(bus.key_held),  0);
    chk("midrst_frame_err", int'(bus.frame_err), 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    ni0 = n_ni;
    fe0 = n_fe;
    send_frame(8'h24, 1'b0, 11);
    chk("post_rst_note_in_cnt", n_ni - ni0, 1);
    chk("post_rst_note",        int'(bus.note), 3);
    chk("post_rst_octave",      int'(bus.octave), 4);
    chk("post_rst_key_held",    int'(bus.key_held), 1);
    chk("post_rst_err_cnt",     n_fe - fe0, 0);

    chk("note_in_back_to_back", n_double, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
